// File: rtl/hamming_dec_arbiter.sv
// Two-requester round-robin front end sharing one Hamming(15,11) single-error
// corrector, with a one-entry registered result slot and per-requester error counters.
module hamming_dec_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [14:0]      req0_cw,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [14:0]      req1_cw,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_id,
    output logic [14:0]      out_cw,
    output logic [10:0]      out_data,
    output logic             out_corr,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1
);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_ptr;
    logic             r_id, r_corr;
    logic [14:0]      r_cw;
    logic [10:0]      r_data;
    logic [CNT_W-1:0] r_cnt0, r_cnt1;

    logic             w_grant, w_free, w_accept, w_corr;
    logic [14:0]      w_cw_in, w_dec;
    logic [3:0]       w_syn;

    // Grant falls back to the RR pointer when neither side is valid.
    always_comb begin
        w_grant = r_ptr;
        if (req0_valid && !req1_valid)
            w_grant = 1'b0;
        else if (req1_valid && !req0_valid)
            w_grant = 1'b1;
    end

    assign w_free     = (r_state == ST_EMPTY) || out_ready;
    assign w_accept   = w_free && (req0_valid || req1_valid) && !rst;
    assign req0_ready = w_free && !w_grant && !rst;
    assign req1_ready = w_free &&  w_grant && !rst;
    assign w_cw_in    = w_grant ? req1_cw : req0_cw;

    // Hamming position p sits at cw bit 15-p; syndrome bit k covers positions with bit k set.
    assign w_syn[0] = ^{w_cw_in[14], w_cw_in[12], w_cw_in[10], w_cw_in[8],
                        w_cw_in[6],  w_cw_in[4],  w_cw_in[2],  w_cw_in[0]};
    assign w_syn[1] = ^{w_cw_in[13], w_cw_in[12], w_cw_in[9],  w_cw_in[8],
                        w_cw_in[5],  w_cw_in[4],  w_cw_in[1],  w_cw_in[0]};
    assign w_syn[2] = ^{w_cw_in[11], w_cw_in[10], w_cw_in[9],  w_cw_in[8],
                        w_cw_in[3],  w_cw_in[2],  w_cw_in[1],  w_cw_in[0]};
    assign w_syn[3] = ^w_cw_in[7:0];

    always_comb begin
        w_dec = w_cw_in;
        if (w_syn != 4'd0)
            w_dec[4'd15 - w_syn] = ~w_cw_in[4'd15 - w_syn];
    end

    assign w_corr = |(w_dec ^ w_cw_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (!w_accept && out_ready) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= 1'b0;
            r_id   <= 1'b0;
            r_cw   <= '0;
            r_data <= '0;
            r_corr <= 1'b0;
        end else if (w_accept) begin
            r_ptr  <= ~w_grant;
            r_id   <= w_grant;
            r_cw   <= w_dec;
            r_data <= {w_dec[12], w_dec[10:8], w_dec[6:0]};
            r_corr <= w_corr;
        end
    end

    // Clear takes precedence over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (cnt_clr) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept && w_corr) begin
            if (!w_grant && (r_cnt0 != '1))
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (w_grant && (r_cnt1 != '1))
                r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_id    = r_id;
    assign out_cw    = r_cw;
    assign out_data  = r_data;
    assign out_corr  = r_corr;
    assign err_cnt0  = r_cnt0;
    assign err_cnt1  = r_cnt1;

endmodule
